// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle mult/multu/div/divu unit for the EX stage.
// Shift-add multiply / restoring divide, one bit per cycle, result in HI/LO.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [5:0]       FunctCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             sa, sb;
  logic             bzero;
  logic [WIDTH-1:0] aorig;
  logic [WIDTH-1:0] mag;
  logic [W2-1:0]    acc;

  logic             fn_ok;
  logic             accept;
  logic             last;
  logic             ld_sgn;
  logic [WIDTH-1:0] amag, bmag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_df;
  logic [W2-1:0]    acc_step;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  // 0x18..0x1B share funct[5:2]; bit 1 selects divide, bit 0 unsigned
  assign fn_ok  = (FunctCode[5:2] == 4'b0110);
  assign accept = Start && fn_ok && (state == IDLE);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign Busy   = (state != IDLE);

  assign ld_sgn = ~FunctCode[0];
  assign amag   = (ld_sgn && A[WIDTH-1]) ? -A : A;
  assign bmag   = (ld_sgn && B[WIDTH-1]) ? -B : B;

  // one iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum = {1'b0, acc[W2-1:WIDTH]}
            + (acc[0] ? {1'b0, mag} : '0);
    div_sh  = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    div_df  = div_sh - {1'b0, mag};
    if (!is_div)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (div_df[WIDTH])
      acc_step = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_step = {div_df[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // sign correction and divide-by-zero override applied in FIX
  always_comb begin
    fix_hi = acc[W2-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (!is_div) begin
      if (sa ^ sb)
        {fix_hi, fix_lo} = -acc;
    end else if (bzero) begin
      fix_hi = aorig;
      fix_lo = '1;
    end else begin
      if (sa ^ sb)
        fix_lo = -acc[WIDTH-1:0];
      if (sa)
        fix_hi = -acc[W2-1:WIDTH];
    end
  end

  // state register
  always_ff @(posedge Clk) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (last) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // operand load, iteration and result write-back
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt       <= '0;
      is_div    <= 1'b0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      bzero     <= 1'b0;
      aorig     <= '0;
      mag       <= '0;
      acc       <= '0;
      Done      <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt       <= '0;
            is_div    <= FunctCode[1];
            sa        <= ld_sgn & A[WIDTH-1];
            sb        <= ld_sgn & B[WIDTH-1];
            bzero     <= (B == '0);
            aorig     <= A;
            DivByZero <= 1'b0;
            if (FunctCode[1]) begin
              mag <= bmag;
              acc <= {{WIDTH{1'b0}}, amag};
            end else begin
              mag <= amag;
              acc <= {{WIDTH{1'b0}}, bmag};
            end
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          HI        <= fix_hi;
          LO        <= fix_lo;
          Done      <= 1'b1;
          DivByZero <= is_div & bzero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed checks of muldiv_sequencer.
// Hand-computed vectors, cycle-accurate Busy/Done timing.
module tb_muldiv_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [5:0]  FunctCode;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        DivByZero;

  int total  = 0;
  int passed = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .FunctCode (FunctCode),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .Done      (Done),
    .HI        (HI),
    .LO        (LO),
    .DivByZero (DivByZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // drive Start for one cycle; returns in cycle 1 of the op
  task automatic issue(input logic [5:0] fn,
                       input logic [31:0] a,
                       input logic [31:0] b);
    FunctCode = fn;
    A = a;
    B = b;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // wait for Done; optionally pulse a stray Start in cycle inj
  task automatic wait_done(input string tag, input int inj);
    int cyc;
    logic bok;
    cyc = 1;
    bok = 1'b1;
    while (!Done && cyc < 60) begin
      if (!Busy) bok = 1'b0;
      if (cyc == inj) begin
        FunctCode = 6'h1A;
        A = 32'h0000_DEAD;
        B = 32'd3;
        Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
      tick();
      cyc++;
    end
    Start = 1'b0;
    chk({tag, "_done_cycle"}, 64'(cyc), 64'd34);
    chk({tag, "_busy_1_33"}, 64'(bok), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    FunctCode = 6'h00;
    A = '0;
    B = '0;
    tick();
    tick();
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);
    chk("rst_dbz", 64'(DivByZero), 64'd0);
    Reset = 1'b0;
    tick();

    issue(6'h19, 32'hFFFF_FFFF, 32'd2);
    chk("multu_busy_c1", 64'(Busy), 64'd1);
    wait_done("multu", 0);
    chk("multu_hi", 64'(HI), 64'h0000_0001);
    chk("multu_lo", 64'(LO), 64'hFFFF_FFFE);
    tick();
    chk("multu_done_1cyc", 64'(Done), 64'd0);

    issue(6'h18, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_neg", 0);
    chk("mult_neg_hi", 64'(HI), 64'hFFFF_FFFF);
    chk("mult_neg_lo", 64'(LO), 64'hFFFF_FFF1);

    issue(6'h18, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_min", 0);
    chk("mult_min_hi", 64'(HI), 64'h4000_0000);
    chk("mult_min_lo", 64'(LO), 64'h0000_0000);

    issue(6'h1A, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 0);
    chk("div_neg_lo", 64'(LO), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(HI), 64'hFFFF_FFFF);

    issue(6'h1B, 32'd100, 32'd7);
    wait_done("divu", 0);
    chk("divu_lo", 64'(LO), 64'd14);
    chk("divu_hi", 64'(HI), 64'd2);

    issue(6'h1B, 32'd100, 32'd0);
    wait_done("divz", 0);
    chk("divz_flag", 64'(DivByZero), 64'd1);
    chk("divz_lo", 64'(LO), 64'hFFFF_FFFF);
    chk("divz_hi", 64'(HI), 64'd100);

    issue(6'h19, 32'd3, 32'd4);
    chk("dbz_clear_c1", 64'(DivByZero), 64'd0);
    wait_done("multu_small", 0);
    chk("multu_small_lo", 64'(LO), 64'd12);
    chk("multu_small_hi", 64'(HI), 64'd0);

    issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 0);
    chk("div_ovf_lo", 64'(LO), 64'h8000_0000);
    chk("div_ovf_hi", 64'(HI), 64'd0);
    chk("div_ovf_flag", 64'(DivByZero), 64'd0);

    issue(6'h1A, 32'd10, 32'hFFFF_FFFD);
    wait_done("div_negb", 0);
    chk("div_negb_lo", 64'(LO), 64'hFFFF_FFFD);
    chk("div_negb_hi", 64'(HI), 64'd1);

    issue(6'h19, 32'h1234_5678, 32'h0000_0010);
    wait_done("inj", 5);
    chk("inj_hi", 64'(HI), 64'h0000_0001);
    chk("inj_lo", 64'(LO), 64'h2345_6780);

    issue(6'h20, 32'd9, 32'd9);
    chk("bad_fn_busy", 64'(Busy), 64'd0);
    chk("bad_fn_done", 64'(Done), 64'd0);
    tick();
    chk("bad_fn_busy2", 64'(Busy), 64'd0);
    chk("bad_fn_hi", 64'(HI), 64'h0000_0001);
    chk("bad_fn_lo", 64'(LO), 64'h2345_6780);

    issue(6'h1A, 32'hFFFF_FF9C, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_hi", 64'(HI), 64'd0);
    chk("midrst_lo", 64'(LO), 64'd0);
    chk("midrst_done", 64'(Done), 64'd0);
    tick();
    chk("midrst_done_c12", 64'(Done), 64'd0);
    issue(6'h19, 32'd7, 32'd6);
    wait_done("post_rst", 0);
    chk("post_rst_lo", 64'(LO), 64'd42);
    chk("post_rst_hi", 64'(HI), 64'd0);

    Reset = 1'b1;
    FunctCode = 6'h19;
    A = 32'd5;
    B = 32'd5;
    Start = 1'b1;
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    chk("rst_start_busy", 64'(Busy), 64'd0);
    tick();
    chk("rst_start_busy2", 64'(Busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
